// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch (IF)
// and the memory stage (ME). Each access runs IDLE -> BUSY_x -> RESP -> IDLE with a
// req/ack handshake to a variable-latency memory. ME wins ties by default.
// Optional feature macro: ARB_STARVE_GUARD_EN. When defined, a saturating counter of
// ME wins over a waiting IF hands the next tie to IF once it reaches STARVE_MAX.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          me_req,
  input  logic          me_we,
  input  logic [AW-1:0] me_addr,
  input  logic [31:0]   me_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   if_rdata,
  output logic          if_done,
  output logic [31:0]   me_rdata,
  output logic          me_done,
  output logic          any_stall
);

  typedef enum logic [2:0] {
    StIdle,
    StBusyIf,
    StBusyMe,
    StRespIf,
    StRespMe
  } state_e;

  // The starvation counter is 3 bits wide, so the threshold must fit in it.
  if (STARVE_MAX > 7) begin : g_bad_starve_max
    $error("STARVE_MAX must fit in 3 bits");
  end

  state_e        state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   me_rdata_q, me_rdata_d;

  logic          idle;
  logic          if_priority;
  logic          grant_me;
  logic          grant_if;

  assign idle = (state_q == StIdle);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

  logic [2:0] starve_q, starve_d;

  // IF takes a tie once ME has beaten a waiting IF StarveMax times in a row.
  assign if_priority = (starve_q == StarveMax);

  // Count ME grants made over a waiting IF; any IF grant clears the count.
  always_comb begin
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = 3'd0;
    end else if (grant_me && if_req && (starve_q != StarveMax)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign if_priority = 1'b0;
`endif

  // Grants are only made from IDLE; ME is the older instruction and wins ties.
  assign grant_me = idle & me_req & ~(if_req & if_priority);
  assign grant_if = idle & if_req & ~grant_me;

  // Next-state and datapath capture for the access sequencer.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    me_rdata_d  = me_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_me) begin
          state_d     = StBusyMe;
          mem_req_d   = 1'b1;
          mem_we_d    = me_we;
          mem_addr_d  = me_addr;
          mem_wdata_d = me_wdata;
        end else if (grant_if) begin
          state_d    = StBusyIf;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      StBusyIf: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          state_d    = StRespIf;
        end
      end
      StBusyMe: begin
        if (mem_ack) begin
          // Writes leave the load-data register untouched.
          if (!mem_we_q) begin
            me_rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = StRespMe;
        end
      end
      StRespIf, StRespMe: begin
        state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      me_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      me_rdata_q  <= me_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign me_rdata  = me_rdata_q;
  assign if_done   = (state_q == StRespIf);
  assign me_done   = (state_q == StRespMe);
  assign any_stall = (if_req & ~if_done) | (me_req & ~me_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        me_req;
  logic        me_we;
  logic [31:0] me_addr;
  logic [31:0] me_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_rdata;
  logic        if_done;
  logic [31:0] me_rdata;
  logic        me_done;
  logic        any_stall;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .AW        (32),
    .STARVE_MAX(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .me_req   (me_req),
    .me_we    (me_we),
    .me_addr  (me_addr),
    .me_wdata (me_wdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .me_rdata (me_rdata),
    .me_done  (me_done),
    .any_stall(any_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || if_done !== 1'b0 || me_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: req=%b we=%b if_done=%b me_done=%b, want all 0",
               mem_req, mem_we, if_done, me_done);
    end
    n_tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h, want 0", mem_addr, mem_wdata);
    end
    n_tests++;
    if (if_rdata !== 32'h0 || me_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: if=%h me=%h, want 0", if_rdata, me_rdata);
    end
    n_tests++;
    if (any_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b want 0", any_stall);
    end
    nxt();
    nxt();
    reset = 1'b1;
    nxt();
  endtask

  task automatic test_if_read();
    // cycle 0
    if_req  = 1'b1;
    if_addr = 32'h40;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL if_c0_req: got %b want 0", mem_req);
    end
    nxt();
    // cycle 1
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL if_c1_bus: req=%b we=%b addr=%h, want 1 0 00000040",
               mem_req, mem_we, mem_addr);
    end
    nxt();
    // cycle 2
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL if_c2_hold: req=%b done=%b, want 1 0", mem_req, if_done);
    end
    nxt();
    // cycle 3: ack
    mem_ack   = 1'b1;
    mem_rdata = 32'h2010FFFF;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL if_c3_ack: req=%b done=%b, want 1 0", mem_req, if_done);
    end
    nxt();
    // cycle 4: done
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b1 || me_done !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL if_c4_done: if_done=%b me_done=%b req=%b, want 1 0 0",
               if_done, me_done, mem_req);
    end
    n_tests++;
    if (if_rdata !== 32'h2010FFFF) begin
      n_fail++;
      $display("FAIL if_rdata: got %h want 2010ffff", if_rdata);
    end
    nxt();
    // cycle 5
    if_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b0 || if_rdata !== 32'h2010FFFF) begin
      n_fail++;
      $display("FAIL if_c5_hold: done=%b rdata=%h, want 0 2010ffff", if_done, if_rdata);
    end
    nxt();
  endtask

  task automatic test_tie();
    // cycle 0: both request
    if_req  = 1'b1;
    if_addr = 32'h44;
    me_req  = 1'b1;
    me_we   = 1'b0;
    me_addr = 32'h80;
    nxt();
    // cycle 1
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_winner: req=%b addr=%h we=%b, want 1 00000080 0",
               mem_req, mem_addr, mem_we);
    end
    nxt();
    // cycle 2: ack
    mem_ack   = 1'b1;
    mem_rdata = 32'h11112222;
    nxt();
    // cycle 3: ME done
    mem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (me_done !== 1'b1 || if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_me_done: me_done=%b if_done=%b, want 1 0", me_done, if_done);
    end
    n_tests++;
    if (me_rdata !== 32'h11112222 || any_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL tie_me_data: rdata=%h stall=%b, want 11112222 1", me_rdata, any_stall);
    end
    nxt();
    // cycle 4: ME drops, IF granted
    me_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0 || me_done !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_c4_idle: req=%b me_done=%b, want 0 0", mem_req, me_done);
    end
    nxt();
    // cycle 5: IF access, ack immediately
    mem_ack   = 1'b1;
    mem_rdata = 32'h33334444;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
      n_fail++;
      $display("FAIL tie_if_grant: req=%b addr=%h, want 1 00000044", mem_req, mem_addr);
    end
    nxt();
    // cycle 6
    mem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b1 || if_rdata !== 32'h33334444 || me_rdata !== 32'h11112222) begin
      n_fail++;
      $display("FAIL tie_if_done: done=%b if_rdata=%h me_rdata=%h, want 1 33334444 11112222",
               if_done, if_rdata, me_rdata);
    end
    nxt();
    if_req = 1'b0;
    nxt();
  endtask

  task automatic test_me_write();
    me_req   = 1'b1;
    me_we    = 1'b1;
    me_addr  = 32'h54;
    me_wdata = 32'hDEADBEEF;
    nxt();
    // cycle 1
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h54 ||
        mem_wdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_bus: req=%b we=%b addr=%h wdata=%h, want 1 1 00000054 deadbeef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    nxt();
    // cycle 2: ack with junk read data
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    nxt();
    // cycle 3
    mem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (me_done !== 1'b1 || mem_we !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: done=%b we=%b req=%b, want 1 0 0", me_done, mem_we, mem_req);
    end
    n_tests++;
    if (me_rdata !== 32'h11112222) begin
      n_fail++;
      $display("FAIL wr_rdata_kept: got %h want 11112222", me_rdata);
    end
    nxt();
    me_req = 1'b0;
    me_we  = 1'b0;
    nxt();
  endtask

  task automatic test_any_stall();
    logic exp_stall [4];
    exp_stall[0] = 1'b1;
    exp_stall[1] = 1'b1;
    exp_stall[2] = 1'b1;
    exp_stall[3] = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h300;
    for (int c = 0; c < 4; c++) begin
      mem_ack   = (c == 2);
      mem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      n_tests++;
      if (any_stall !== exp_stall[c] || if_done !== (c == 3)) begin
        n_fail++;
        $display("FAIL stall_c%0d: stall=%b done=%b, want %b %b",
                 c, any_stall, if_done, exp_stall[c], (c == 3));
      end
      nxt();
    end
    mem_ack = 1'b0;
    if_req  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (any_stall !== 1'b0 || if_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL stall_after: stall=%b rdata=%h, want 0 cafef00d", any_stall, if_rdata);
    end
    nxt();
  endtask

  task automatic test_starve_guard();
    int me_cnt = 0;
    int me_before_if = -1;
    int both_cnt = 0;
    bit if_seen = 1'b0;
    int exp_me;
`ifdef ARB_STARVE_GUARD_EN
    exp_me = 4;
`else
    exp_me = 6;
`endif
    if_req  = 1'b1;
    if_addr = 32'h100;
    me_req  = 1'b1;
    me_we   = 1'b0;
    me_addr = 32'h200;
    for (int c = 0; c < 60 && !if_seen; c++) begin
      mem_ack   = mem_req;
      mem_rdata = 32'h5000 + c;
      @(negedge clk);
      if (me_done && if_done) both_cnt++;
      if (me_done) me_cnt++;
      if (if_done) begin
        if_seen      = 1'b1;
        me_before_if = me_cnt;
      end
      nxt();
`ifndef ARB_STARVE_GUARD_EN
      if (me_cnt == 6) me_req = 1'b0;
`endif
    end
    mem_ack = 1'b0;
    if_req  = 1'b0;
    me_req  = 1'b0;
    n_tests++;
    if (if_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL starve_if_served: no if_done within 60 cycles, want one");
    end
    n_tests++;
    if (me_before_if != exp_me) begin
      n_fail++;
      $display("FAIL starve_me_count: %0d ME accesses before IF, want %0d",
               me_before_if, exp_me);
    end
    n_tests++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL starve_both_done: %0d cycles with both dones, want 0", both_cnt);
    end
    nxt();
    nxt();
  endtask

  task automatic test_reset_mid();
    me_req  = 1'b1;
    me_we   = 1'b0;
    me_addr = 32'h3C;
    nxt();
    // cycle 1: BUSY_ME
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3C) begin
      n_fail++;
      $display("FAIL rst_busy: req=%b addr=%h, want 1 0000003c", mem_req, mem_addr);
    end
    nxt();
    // cycle 2: asynchronous reset mid-access
    reset = 1'b0;
    #1;
    n_tests++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || me_done !== 1'b0 || if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: req=%b addr=%h me_done=%b if_done=%b, want 0 0 0 0",
               mem_req, mem_addr, me_done, if_done);
    end
    n_tests++;
    if (me_rdata !== 32'h0 || if_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: me=%h if=%h, want 0 0", me_rdata, if_rdata);
    end
    me_req = 1'b0;
    nxt();
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77778888;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0 || me_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_late_ack: req=%b me_done=%b, want 0 0", mem_req, me_done);
    end
    nxt();
    mem_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (me_done !== 1'b0 || if_done !== 1'b0 || me_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_no_done: me_done=%b if_done=%b me_rdata=%h, want 0 0 0",
               me_done, if_done, me_rdata);
    end
    nxt();
  endtask

  initial begin
    reset     = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    me_req    = 1'b0;
    me_we     = 1'b0;
    me_addr   = 32'h0;
    me_wdata  = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_if_read();
    test_tie();
    test_me_write();
    test_any_stall();
    test_starve_guard();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
